// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges two in-order write-back lanes into the two write ports of a banked
// (even/odd) register file. At most one write per bank issues per cycle.
// Writes that cannot issue wait in a small in-order queue. Program order is
// always preserved, and writes to r0 are dropped.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wb{0,1}_valid/addr/data_i    write-back lanes (lane 0 is older)
//   wb_ready_o                   both lanes are accepted this cycle
//   rf_we/wa/wd{0,1}_o           register-file write ports (port 0 is older)
//   pending_o                    queue occupancy
//   idle_o                       queue empty and no write presented
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INIT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb0_valid_i,
    input  logic [4:0]                 wb0_addr_i,
    input  logic [WIDTH-1:0]           wb0_data_i,
    input  logic                       wb1_valid_i,
    input  logic [4:0]                 wb1_addr_i,
    input  logic [WIDTH-1:0]           wb1_data_i,
    output logic                       wb_ready_o,
    output logic                       rf_we0_o,
    output logic [4:0]                 rf_wa0_o,
    output logic [WIDTH-1:0]           rf_wd0_o,
    output logic                       rf_we1_o,
    output logic [4:0]                 rf_wa1_o,
    output logic [WIDTH-1:0]           rf_wd1_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       idle_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);

    typedef struct packed {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t           q_mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic          ready_q, ready_d;
    logic          idle_q, idle_d;
    logic          we0_q, we1_q;
    wr_t           port0_q, port1_q;

    wr_t           cand [4];
    logic [3:0]    cand_v;
    logic [1:0]    a_idx, b_idx, n_sel;
    logic          acc0, acc1;
    logic          issue_a, issue_b;
    logic          lane0_iss, lane1_iss, enq0, enq1;
    logic [CW-1:0] deq_cnt;
    logic [PW-1:0] head_p1, wr_idx1;

    // Candidate list in age order: two oldest queue entries, then the lanes
    always_comb begin
        acc0    = wb0_valid_i & ready_q & (wb0_addr_i != 5'd0);
        acc1    = wb1_valid_i & ready_q & (wb1_addr_i != 5'd0);
        head_p1 = head_q + PW'(1);
        cand[0] = q_mem[head_q];
        cand[1] = q_mem[head_p1];
        cand[2] = '{addr: wb0_addr_i, data: wb0_data_i};
        cand[3] = '{addr: wb1_addr_i, data: wb1_data_i};
        cand_v  = {acc1, acc0, (count_q >= CW'(2)), (count_q != '0)};
    end

    // Pick the first two valid candidates; the second issues only on the other bank
    always_comb begin
        a_idx = 2'd0;
        b_idx = 2'd0;
        n_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cand_v[i]) begin
                if (n_sel == 2'd0) begin
                    a_idx = 2'(i);
                end else if (n_sel == 2'd1) begin
                    b_idx = 2'(i);
                end
                if (n_sel != 2'd2) begin
                    n_sel = n_sel + 2'd1;
                end
            end
        end
        issue_a = (n_sel != 2'd0);
        issue_b = (n_sel == 2'd2) && (cand[b_idx].addr[0] != cand[a_idx].addr[0]);
    end

    // Queue bookkeeping and next-state of the registered outputs
    always_comb begin
        lane0_iss  = (issue_a && a_idx == 2'd2) || (issue_b && b_idx == 2'd2);
        lane1_iss  = (issue_a && a_idx == 2'd3) || (issue_b && b_idx == 2'd3);
        enq0       = acc0 & ~lane0_iss;
        enq1       = acc1 & ~lane1_iss;
        deq_cnt    = CW'(issue_a & ~a_idx[1]) + CW'(issue_b & ~b_idx[1]);
        count_d    = count_q - deq_cnt + CW'(enq0) + CW'(enq1);
        head_d     = head_q + PW'(deq_cnt);
        tail_d     = tail_q + PW'(enq0) + PW'(enq1);
        wr_idx1    = enq0 ? (tail_q + PW'(1)) : tail_q;
        init_cnt_d = (init_cnt_q == IW'(INIT_CYCLES)) ? init_cnt_q : (init_cnt_q + IW'(1));
        // Two free slots are kept so a full pair can always be absorbed
        ready_d    = (init_cnt_d == IW'(INIT_CYCLES)) && (count_d <= CW'(DEPTH - 2));
        idle_d     = (count_d == '0) && !issue_a && !issue_b;
    end

    // Control state and registered write ports
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            idle_q     <= 1'b1;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            port0_q    <= '0;
            port1_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            idle_q     <= idle_d;
            we0_q      <= issue_a;
            we1_q      <= issue_b;
            if (issue_a) begin
                port0_q <= cand[a_idx];
            end
            if (issue_b) begin
                port1_q <= cand[b_idx];
            end
        end
    end

    // Queue storage; contents are don't-care outside the head..tail window
    always_ff @(posedge clk) begin
        if (!rst && enq0) begin
            q_mem[tail_q] <= cand[2];
        end
        if (!rst && enq1) begin
            q_mem[wr_idx1] <= cand[3];
        end
    end

    assign wb_ready_o = ready_q;
    assign rf_we0_o   = we0_q;
    assign rf_wa0_o   = port0_q.addr;
    assign rf_wd0_o   = port0_q.data;
    assign rf_we1_o   = we1_q;
    assign rf_wa1_o   = port1_q.addr;
    assign rf_wd1_o   = port1_q.data;
    assign pending_o  = count_q;
    assign idle_o     = idle_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. Stimulus pushes the expected
// register-file writes in program order with their expected port; a monitor
// pops and compares every write the DUT presents.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 4;
    localparam int INIT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb0_valid_i, wb1_valid_i;
    logic [4:0]        wb0_addr_i, wb1_addr_i;
    logic [WIDTH-1:0]  wb0_data_i, wb1_data_i;
    logic              wb_ready_o;
    logic              rf_we0_o, rf_we1_o;
    logic [4:0]        rf_wa0_o, rf_wa1_o;
    logic [WIDTH-1:0]  rf_wd0_o, rf_wd1_o;
    logic [2:0]        pending_o;
    logic              idle_o;

    regfile_wb_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .wb0_valid_i(wb0_valid_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
        .wb1_valid_i(wb1_valid_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
        .wb_ready_o(wb_ready_o),
        .rf_we0_o(rf_we0_o), .rf_wa0_o(rf_wa0_o), .rf_wd0_o(rf_wd0_o),
        .rf_we1_o(rf_we1_o), .rf_wa1_o(rf_wa1_o), .rf_wd1_o(rf_wd1_o),
        .pending_o(pending_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed occupancy/ready for an even-only pair stream
    int pend_a1 [7] = '{0, 1, 2, 3, 2, 3, 2};
    int rdy_a1  [7] = '{1, 1, 1, 0, 1, 0, 1};
    int drain_a1 [4] = '{3, 2, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic pop_cmp(input int port, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write port=%0d addr=%0d data=0x%0h required=none", port, a, d);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("wr_port_r%0d", e.addr), port, e.port);
            chk($sformatf("wr_addr_r%0d", e.addr), {27'd0, a}, {27'd0, e.addr});
            chk($sformatf("wr_data_r%0d", e.addr), d, e.data);
        end
    endtask

    // Monitor: sample after each active edge, in port order (port 0 is older)
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rf_we0_o && rf_we1_o)
                chk("bank_split", {31'd0, rf_wa0_o[0] ^ rf_wa1_o[0]}, 32'd1);
            if (rf_we0_o) pop_cmp(0, rf_wa0_o, rf_wd0_o);
            if (rf_we1_o) pop_cmp(1, rf_wa1_o, rf_wd1_o);
        end
    end

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
        wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    endtask

    task automatic expect_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the negedge where rst was just dropped (the period ending at edge 0)
    task automatic init_window();
        for (int c = 0; c <= INIT_CYCLES; c++) begin
            chk($sformatf("init_ready_c%0d", c), {31'd0, wb_ready_o}, (c == INIT_CYCLES) ? 32'd1 : 32'd0);
            chk($sformatf("init_we_c%0d", c), {30'd0, rf_we1_o, rf_we0_o}, 32'd0);
            chk($sformatf("init_idle_c%0d", c), {31'd0, idle_o}, 32'd1);
            if (c < INIT_CYCLES) tick();
        end
    endtask

    task automatic chk_cycle(input string name, input logic we0, input logic we1, input int pend);
        chk({name, "_we0"}, {31'd0, rf_we0_o}, {31'd0, we0});
        chk({name, "_we1"}, {31'd0, rf_we1_o}, {31'd0, we1});
        chk({name, "_pending"}, {29'd0, pending_o}, pend);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        tick();
        chk("rst_ready", {31'd0, wb_ready_o}, 32'd0);
        chk("rst_idle", {31'd0, idle_o}, 32'd1);
        chk_cycle("rst", 1'b0, 1'b0, 0);
        chk("rst_wa", {22'd0, rf_wa1_o, rf_wa0_o}, 32'd0);
        chk("rst_wd", rf_wd0_o | rf_wd1_o, 32'd0);
        rst = 1'b0;
        init_window();

        // Bypass, different banks
        drive(1, 5'd4, 32'hA, 1, 5'd7, 32'hB);
        expect_wr(0, 5'd4, 32'hA);
        expect_wr(1, 5'd7, 32'hB);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk_cycle("bypass", 1'b1, 1'b1, 0);

        // Same-bank conflict
        drive(1, 5'd2, 32'h1, 1, 5'd6, 32'h2);
        expect_wr(0, 5'd2, 32'h1);
        expect_wr(0, 5'd6, 32'h2);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk_cycle("conflict_c1", 1'b1, 1'b0, 1);
        tick();
        chk_cycle("conflict_c2", 1'b1, 1'b0, 0);

        // Same-register ordering
        drive(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
        expect_wr(0, 5'd5, 32'h11);
        expect_wr(0, 5'd5, 32'h22);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk_cycle("samereg_c1", 1'b1, 1'b0, 1);
        tick();
        chk_cycle("samereg_c2", 1'b1, 1'b0, 0);

        // r0 drop
        drive(1, 5'd0, 32'hFF, 1, 5'd3, 32'h9);
        expect_wr(0, 5'd3, 32'h9);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk_cycle("r0drop_c1", 1'b1, 1'b0, 0);
        tick();
        chk("r0drop_idle", {31'd0, idle_o}, 32'd1);
        chk("r0drop_we0", {31'd0, rf_we0_o}, 32'd0);

        // Two-entry dequeue across the pointer wrap, then 2-in/2-out at count 2
        drive(1, 5'd2, 32'h200, 1, 5'd4, 32'h201);
        expect_wr(0, 5'd2, 32'h200);
        expect_wr(0, 5'd4, 32'h201);
        tick();
        chk_cycle("wrap_v0", 1'b1, 1'b0, 1);
        drive(1, 5'd6, 32'h202, 1, 5'd9, 32'h203);
        expect_wr(0, 5'd6, 32'h202);
        expect_wr(1, 5'd9, 32'h203);
        tick();
        chk_cycle("wrap_v1", 1'b1, 1'b0, 2);
        chk("wrap_v1_ready", {31'd0, wb_ready_o}, 32'd1);
        drive(1, 5'd8, 32'h204, 1, 5'd11, 32'h205);
        expect_wr(0, 5'd8, 32'h204);
        expect_wr(1, 5'd11, 32'h205);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk_cycle("wrap_v2", 1'b1, 1'b1, 2);
        tick();
        chk_cycle("wrap_v3", 1'b1, 1'b1, 0);
        tick();
        chk("wrap_idle", {31'd0, idle_o}, 32'd1);

        // Even-only stream: backpressure, junk while not ready must be ignored
        k = 0;
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("stream_pending_t%0d", t), {29'd0, pending_o}, pend_a1[t]);
            chk($sformatf("stream_ready_t%0d", t), {31'd0, wb_ready_o}, rdy_a1[t]);
            if (rdy_a1[t] == 1) begin
                drive(1, 5'(2 + 2 * (k % 15)), 32'h100 + k,
                      1, 5'(2 + 2 * ((k + 1) % 15)), 32'h100 + k + 1);
                expect_wr(0, 5'(2 + 2 * (k % 15)), 32'h100 + k);
                expect_wr(0, 5'(2 + 2 * ((k + 1) % 15)), 32'h100 + k + 1);
                k += 2;
            end else begin
                drive(1, 5'd6, 32'hDEAD_0000 + t, 1, 5'd12, 32'hDEAD_1000 + t);
            end
            tick();
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("drain_pending_t%0d", t), {29'd0, pending_o}, drain_a1[t]);
            tick();
        end

        // Refill to count 3, then reset mid-operation
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("refill_pending_t%0d", t), {29'd0, pending_o}, t);
            drive(1, 5'(2 + 2 * (k % 15)), 32'h100 + k,
                  1, 5'(2 + 2 * ((k + 1) % 15)), 32'h100 + k + 1);
            expect_wr(0, 5'(2 + 2 * (k % 15)), 32'h100 + k);
            expect_wr(0, 5'(2 + 2 * ((k + 1) % 15)), 32'h100 + k + 1);
            k += 2;
            tick();
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("full_pending", {29'd0, pending_o}, 32'd3);
        chk("full_ready", {31'd0, wb_ready_o}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk_cycle("midrst", 1'b0, 1'b0, 0);
        chk("midrst_idle", {31'd0, idle_o}, 32'd1);
        chk("midrst_ready", {31'd0, wb_ready_o}, 32'd0);
        rst = 1'b0;
        init_window();

        tick();
        tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
